// File: rtl/pll_reconfig_seq.sv
// Runtime reprogramming sequencer for the fractional PLL reconfig controller.
// Writes M/K/C0, starts reconfig, polls status, then waits for a stable lock.
module pll_reconfig_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned LOCK_STABLE    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [17:0] cfg_m,
    input  logic [31:0] cfg_k,
    input  logic [17:0] cfg_c0,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        locked_sync
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_M,
        S_WR_K,
        S_WR_C,
        S_WR_START,
        S_RD_STATUS,
        S_WAIT_LOCK,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [17:0]   m_q, m_d;
    logic [31:0]   k_q, k_d;
    logic [17:0]   c0_q, c0_d;
    logic          error_q, error_d;
    logic          gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] stb_q, stb_d;
    logic          sync1_q, sync2_q;
    logic [TW-1:0] tmo_inc;
    logic          expired;
    logic          unused_rd;

    assign unused_rd   = ^mgmt_readdata[31:1];
    assign locked_sync = sync2_q;
    assign busy        = (state_q != S_IDLE);
    assign error       = error_q;

    // Saturating so a stalled read cannot wrap the counter past the limit
    assign tmo_inc = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TW'(1);
    assign expired = (tmo_inc == TMO_LAST);

    always_comb begin
        state_d        = state_q;
        m_d            = m_q;
        k_d            = k_q;
        c0_d           = c0_q;
        error_d        = error_q;
        gap_d          = gap_q;
        tmo_d          = tmo_q;
        stb_d          = stb_q;
        mgmt_address   = 6'h00;
        mgmt_write     = 1'b0;
        mgmt_read      = 1'b0;
        mgmt_writedata = 32'h0;
        done           = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_req) begin
                    m_d     = cfg_m;
                    k_d     = cfg_k;
                    c0_d    = cfg_c0;
                    error_d = 1'b0;
                    state_d = S_WR_MODE;
                end
            end
            S_WR_MODE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h00;
                mgmt_writedata = 32'h1;
                if (!mgmt_waitrequest) state_d = S_WR_M;
            end
            S_WR_M: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h04;
                mgmt_writedata = {14'b0, m_q};
                if (!mgmt_waitrequest) state_d = S_WR_K;
            end
            S_WR_K: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h07;
                mgmt_writedata = k_q;
                if (!mgmt_waitrequest) state_d = S_WR_C;
            end
            S_WR_C: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h05;
                mgmt_writedata = {9'b0, 5'd0, c0_q};
                if (!mgmt_waitrequest) state_d = S_WR_START;
            end
            S_WR_START: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h02;
                mgmt_writedata = 32'h0;
                if (!mgmt_waitrequest) begin
                    tmo_d   = '0;
                    gap_d   = 1'b0;
                    state_d = S_RD_STATUS;
                end
            end
            S_RD_STATUS: begin
                tmo_d        = tmo_inc;
                mgmt_address = 6'h01;
                mgmt_read    = !gap_q;
                if (gap_q) begin
                    gap_d = 1'b0;
                    if (expired) begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end
                end else if (!mgmt_waitrequest) begin
                    if (expired) begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end else if (mgmt_readdata[0]) begin
                        stb_d   = '0;
                        state_d = S_WAIT_LOCK;
                    end else begin
                        gap_d = 1'b1;
                    end
                end
            end
            S_WAIT_LOCK: begin
                tmo_d = tmo_inc;
                stb_d = locked_sync ? stb_q + SW'(1) : '0;
                if (expired) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else if (locked_sync && stb_q == STB_LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            k_q     <= '0;
            c0_q    <= '0;
            error_q <= 1'b0;
            gap_q   <= 1'b0;
            tmo_q   <= '0;
            stb_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
            c0_q    <= c0_d;
            error_q <= error_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            stb_q   <= stb_d;
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

endmodule
